cpu_bus_ctrl: RTL and testbench

CPU_BUS_CTRL -- requirements
Module: cpu_bus_ctrl

---
 rtl/cpu_bus_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_cpu_bus_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_ctrl.sv
// rtl/cpu_bus_ctrl.sv - CPU bus controller decoding RAM, IO and ROM regions
//
// Purpose: converts each CPU access into a RAM, ROM or IO cycle and
// returns a single-cycle rdy pulse when the access completes.
// RAM accesses take no extra wait cycles. ROM accesses add ROM_WAIT
// wait cycles. IO accesses use a req/ack handshake with a timeout.
//
// Ports:
//   clk, res               clock and synchronous active-high reset
//   add_bus, d_out         CPU address and write data
//   write_en               CPU write strobe, active-low
//   d_in, rdy              registered read data and completion pulse to the CPU
//   mem_addr, mem_wdata    latched address [14:0] and write data for RAM/ROM
//   mem_we                 RAM write strobe
//   ram_cs, rom_cs         region chip selects
//   ram_rdata, rom_rdata   asynchronous-read memory data
//   io_req, io_we          IO request and direction (1 = write)
//   io_ack, io_rdata       IO completion and read data
//   bus_err                one-cycle pulse, coincident with rdy, on IO timeout
module cpu_bus_ctrl #(
  parameter int unsigned ROM_WAIT   = 2,
  parameter int unsigned IO_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        res,
  input  logic [15:0] add_bus,
  input  logic [7:0]  d_out,
  input  logic        write_en,
  output logic [7:0]  d_in,
  output logic        rdy,
  output logic [14:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        ram_cs,
  output logic        rom_cs,
  input  logic [7:0]  ram_rdata,
  input  logic [7:0]  rom_rdata,
  output logic        io_req,
  output logic        io_we,
  input  logic        io_ack,
  input  logic [7:0]  io_rdata,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_IO,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    RG_RAM,
    RG_IO,
    RG_ROM
  } region_t;

  localparam logic [3:0] WAIT_LOAD = 4'(ROM_WAIT);
  localparam logic [7:0] TMO_LIMIT = 8'(IO_TIMEOUT);

  state_t      state;
  state_t      state_nx;
  region_t     region;
  region_t     addr_region;
  logic        wr_lat;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_nx;
  logic [7:0]  io_cnt;
  logic [7:0]  io_nx;
  logic [7:0]  io_inc;
  logic [7:0]  d_in_nx;
  logic        berr_nx;
  logic        capture;
  logic        active;

  // Bit 15 clear selects RAM; otherwise bit 14 splits IO from ROM.
  always_comb begin
    addr_region = RG_RAM;
    if (add_bus[15]) begin
      addr_region = add_bus[14] ? RG_ROM : RG_IO;
    end
  end

  assign io_inc = io_cnt + 8'd1;

  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    io_nx    = io_cnt;
    d_in_nx  = d_in;
    berr_nx  = 1'b0;
    capture  = 1'b0;

    case (state)
      S_IDLE: begin
        wait_nx  = 4'd0;
        io_nx    = 8'd0;
        state_nx = (addr_region == RG_IO) ? S_IO : S_ACCESS;
      end

      S_ACCESS: begin
        if ((region == RG_ROM) && (WAIT_LOAD != 4'd0)) begin
          wait_nx  = WAIT_LOAD;
          state_nx = S_WAIT;
        end else begin
          capture  = 1'b1;
          state_nx = S_DONE;
        end
      end

      S_WAIT: begin
        // Counter holds the wait cycles still to run, including this one.
        if (wait_cnt <= 4'd1) begin
          wait_nx  = 4'd0;
          capture  = 1'b1;
          state_nx = S_DONE;
        end else begin
          wait_nx = wait_cnt - 4'd1;
        end
      end

      S_IO: begin
        // An ack on the timeout cycle is checked first, so it wins.
        if (io_ack) begin
          if (!wr_lat) begin
            d_in_nx = io_rdata;
          end
          state_nx = S_DONE;
        end else if (io_inc == TMO_LIMIT) begin
          io_nx    = io_inc;
          berr_nx  = 1'b1;
          if (!wr_lat) begin
            d_in_nx = 8'hFF;
          end
          state_nx = S_DONE;
        end else begin
          io_nx = io_inc;
        end
      end

      S_DONE: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase

    // Memory read data is sampled on the edge that ends the last select cycle.
    if (capture && !wr_lat) begin
      d_in_nx = (region == RG_ROM) ? rom_rdata : ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= S_IDLE;
      region    <= RG_RAM;
      wr_lat    <= 1'b0;
      wait_cnt  <= 4'd0;
      io_cnt    <= 8'd0;
      mem_addr  <= 15'd0;
      mem_wdata <= 8'd0;
      d_in      <= 8'd0;
      rdy       <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      io_cnt   <= io_nx;
      d_in     <= d_in_nx;
      rdy      <= (state_nx == S_DONE);
      bus_err  <= berr_nx;
      if (state == S_IDLE) begin
        mem_addr  <= add_bus[14:0];
        mem_wdata <= d_out;
        wr_lat    <= ~write_en;
        region    <= addr_region;
      end
    end
  end

  // Strobes decode straight from the state register, so IDLE and DONE
  // can never drive them.
  assign active = (state == S_ACCESS) || (state == S_WAIT);
  assign ram_cs = active && (region == RG_RAM);
  assign rom_cs = active && (region == RG_ROM);
  assign mem_we = ram_cs && wr_lat;
  assign io_req = (state == S_IO);
  assign io_we  = io_req && wr_lat;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb/tb_cpu_bus_ctrl.sv - randomized self-checking bench for cpu_bus_ctrl
module tb_cpu_bus_ctrl;

  localparam int ROM_WAIT   = 2;
  localparam int IO_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        res;
  logic [15:0] add_bus;
  logic [7:0]  d_out;
  logic        write_en;
  logic [7:0]  d_in;
  logic        rdy;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        ram_cs;
  logic        rom_cs;
  logic [7:0]  ram_rdata;
  logic [7:0]  rom_rdata;
  logic        io_req;
  logic        io_we;
  logic        io_ack;
  logic [7:0]  io_rdata;
  logic        bus_err;

  cpu_bus_ctrl #(.ROM_WAIT(ROM_WAIT), .IO_TIMEOUT(IO_TIMEOUT)) dut (
    .clk(clk), .res(res), .add_bus(add_bus), .d_out(d_out), .write_en(write_en),
    .d_in(d_in), .rdy(rdy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .ram_cs(ram_cs), .rom_cs(rom_cs), .ram_rdata(ram_rdata),
    .rom_rdata(rom_rdata), .io_req(io_req), .io_we(io_we), .io_ack(io_ack),
    .io_rdata(io_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Environment memories.
  logic [7:0] ram_arr [32768];
  logic [7:0] rom_arr [32768];
  assign ram_rdata = ram_arr[mem_addr];
  assign rom_rdata = rom_arr[mem_addr];
  always @(posedge clk) if (mem_we === 1'b1) ram_arr[mem_addr] <= mem_wdata;

  // Reference model state.
  logic [7:0] model_ram [32768];
  logic [7:0] model_d;

  typedef struct packed {
    logic        rdy;
    logic        ram_cs;
    logic        rom_cs;
    logic        mem_we;
    logic        io_req;
    logic        io_we;
    logic        bus_err;
    logic [7:0]  d_in;
    logic        chk_addr;
    logic [14:0] addr;
    logic [7:0]  wdata;
  } exp_t;

  exp_t expq [$];

  int total = 0;
  int bad   = 0;
  int cyc = 0, last_rdy_cyc = 0, last_berr_cyc = 0;
  int n_ram_cs = 0, n_rom_cs = 0, n_we = 0, n_rdy = 0, n_berr = 0;
  int c0, s_ram, s_rom, s_we, s_rdy, s_berr;

  logic [15:0] bnd [6] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hBFFF, 16'hC000, 16'hFFFF};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp_v);
    end
  endtask

  // Per-cycle compare against the model's expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("rdy", 32'(rdy), 32'(e.rdy));
        chk("ram_cs", 32'(ram_cs), 32'(e.ram_cs));
        chk("rom_cs", 32'(rom_cs), 32'(e.rom_cs));
        chk("mem_we", 32'(mem_we), 32'(e.mem_we));
        chk("io_req", 32'(io_req), 32'(e.io_req));
        chk("io_we", 32'(io_we), 32'(e.io_we));
        chk("bus_err", 32'(bus_err), 32'(e.bus_err));
        chk("d_in", 32'(d_in), 32'(e.d_in));
        if (e.chk_addr) begin
          chk("mem_addr", 32'(mem_addr), 32'(e.addr));
          chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
        end
      end
      if (rdy === 1'b1) begin last_rdy_cyc = cyc; n_rdy++; end
      if (bus_err === 1'b1) begin last_berr_cyc = cyc; n_berr++; end
      if (ram_cs === 1'b1) n_ram_cs++;
      if (rom_cs === 1'b1) n_rom_cs++;
      if (mem_we === 1'b1) n_we++;
    end
  end

  task automatic rst_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      res      = 1'b1;
      add_bus  = 16'($urandom);
      d_out    = 8'($urandom);
      write_en = 1'($urandom);
      io_ack   = 1'($urandom);
      io_rdata = 8'($urandom);
      e = '0;
      expq.push_back(e);
    end
    model_d = 8'h00;
  endtask

  // One CPU access. abort_mode: 0 none, -1 random cycle (ROM/IO only), >0 that cycle.
  task automatic xact(input logic [15:0] a, input logic [7:0] wd, input logic wr,
                      input int ack_k, input logic [7:0] io_d, input int abort_mode);
    exp_t e;
    int region, act, tot, ab;
    bit tmo, aborted;
    logic [7:0] new_d;
    region = a[15] ? (a[14] ? 2 : 1) : 0;
    tmo = 1'b0;
    if (region == 0) act = 1;
    else if (region == 2) act = 1 + ROM_WAIT;
    else begin
      act = (ack_k <= IO_TIMEOUT) ? ack_k : IO_TIMEOUT;
      tmo = (ack_k > IO_TIMEOUT);
    end
    tot = act + 2;
    new_d = model_d;
    if (!wr) begin
      if (region == 0) new_d = model_ram[a[14:0]];
      else if (region == 2) new_d = rom_arr[a[14:0]];
      else new_d = tmo ? 8'hFF : io_d;
    end
    ab = 0;
    if (abort_mode > 0) ab = abort_mode;
    else if (abort_mode < 0 && region != 0) ab = $urandom_range(1, tot - 1);
    aborted = 1'b0;
    for (int c = 1; c <= tot; c++) begin
      @(posedge clk); #1;
      res      = (c == ab);
      add_bus  = a;
      d_out    = wd;
      write_en = ~wr;
      io_rdata = 8'($urandom);
      if (region == 1 && c >= 2 && c <= act + 1) begin
        io_ack = (c - 1 == ack_k);
        if (c - 1 == ack_k) io_rdata = io_d;
      end else begin
        io_ack = 1'($urandom);
      end
      e = '0;
      e.d_in = (c == tot) ? new_d : model_d;
      if (c >= 2 && c <= act + 1) begin
        e.ram_cs   = (region == 0);
        e.rom_cs   = (region == 2);
        e.mem_we   = (region == 0) && wr;
        e.io_req   = (region == 1);
        e.io_we    = (region == 1) && wr;
        e.chk_addr = 1'b1;
        e.addr     = a[14:0];
        e.wdata    = wd;
      end
      if (c == tot) begin
        e.rdy     = 1'b1;
        e.bus_err = tmo;
      end
      expq.push_back(e);
      if (c == ab) begin
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      rst_cycles(2);
    end else begin
      model_d = new_d;
      if (region == 0 && wr) model_ram[a[14:0]] = wd;
    end
  endtask

  task automatic snap();
    c0 = cyc; s_ram = n_ram_cs; s_rom = n_rom_cs; s_we = n_we; s_rdy = n_rdy; s_berr = n_berr;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    logic [15:0] a, lo;
    int r;
    res = 1'b1; add_bus = 16'h0; d_out = 8'h0; write_en = 1'b1;
    io_ack = 1'b0; io_rdata = 8'h0; model_d = 8'h00;
    for (int i = 0; i < 32768; i++) begin
      ram_arr[i]   = 8'($urandom);
      model_ram[i] = ram_arr[i];
      rom_arr[i]   = 8'($urandom);
    end
    rom_arr[15'h7FFC]   = 8'h00;
    ram_arr[15'h1234]   = 8'h5A; model_ram[15'h1234] = 8'h5A;
    ram_arr[15'h0055]   = 8'h66; model_ram[15'h0055] = 8'h66;

    rst_cycles(2);
    settle();
    chk("reset_d_in", 32'(d_in), 32'h00);
    chk("reset_rdy", 32'(rdy), 32'h0);

    snap(); xact(16'h1234, 8'h00, 1'b0, 0, 8'h00, 0); settle();
    chk("ram_rd_lat", 32'(last_rdy_cyc - c0), 32'd3);
    chk("ram_rd_data", 32'(d_in), 32'h5A);
    chk("ram_rd_cs_cycles", 32'(n_ram_cs - s_ram), 32'd1);

    snap(); xact(16'hC000, 8'h11, 1'b1, 0, 8'h00, 0); settle();
    chk("rom_wr_lat", 32'(last_rdy_cyc - c0), 32'd5);
    chk("rom_wr_no_we", 32'(n_we - s_we), 32'd0);
    chk("rom_wr_d_in_held", 32'(d_in), 32'h5A);

    snap(); xact(16'h0200, 8'hA7, 1'b1, 0, 8'h00, 0); settle();
    chk("ram_wr_lat", 32'(last_rdy_cyc - c0), 32'd3);
    chk("ram_wr_we_cycles", 32'(n_we - s_we), 32'd1);
    chk("ram_wr_mem", 32'(ram_arr[15'h0200]), 32'hA7);

    snap(); xact(16'hFFFC, 8'h00, 1'b0, 0, 8'h00, 0); settle();
    chk("rom_rd_lat", 32'(last_rdy_cyc - c0), 32'd5);
    chk("rom_rd_cs_cycles", 32'(n_rom_cs - s_rom), 32'd3);
    chk("rom_rd_data", 32'(d_in), 32'h00);

    snap(); xact(16'h8001, 8'h00, 1'b0, 4, 8'h3C, 0); settle();
    chk("io_rd_lat", 32'(last_rdy_cyc - c0), 32'd6);
    chk("io_rd_data", 32'(d_in), 32'h3C);
    chk("io_rd_no_err", 32'(n_berr - s_berr), 32'd0);

    snap(); xact(16'h8001, 8'h00, 1'b0, 100, 8'h00, 0); settle();
    chk("io_tmo_lat", 32'(last_rdy_cyc - c0), 32'd17);
    chk("io_tmo_data", 32'(d_in), 32'hFF);
    chk("io_tmo_err_cnt", 32'(n_berr - s_berr), 32'd1);
    chk("io_tmo_err_with_rdy", 32'(last_berr_cyc - c0), 32'd17);

    snap(); xact(16'h8002, 8'h00, 1'b0, IO_TIMEOUT, 8'h81, 0); settle();
    chk("io_ack_at_tmo_lat", 32'(last_rdy_cyc - c0), 32'd17);
    chk("io_ack_at_tmo_no_err", 32'(n_berr - s_berr), 32'd0);
    chk("io_ack_at_tmo_data", 32'(d_in), 32'h81);

    snap(); xact(16'hFFFC, 8'h00, 1'b0, 0, 8'h00, 3); settle();
    chk("abort_no_rdy", 32'(n_rdy - s_rdy), 32'd0);
    chk("abort_d_in", 32'(d_in), 32'h00);

    snap(); xact(16'h0055, 8'h00, 1'b0, 0, 8'h00, 0); settle();
    chk("post_abort_lat", 32'(last_rdy_cyc - c0), 32'd3);
    chk("post_abort_data", 32'(d_in), 32'h66);

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) begin
        a = bnd[$urandom_range(0, 5)];
      end else begin
        lo = 16'($urandom_range(0, 15));
        a = (r == 0) ? lo : ((r == 1) ? (16'h8000 | lo) : (16'hC000 | lo));
      end
      xact(a, 8'($urandom), 1'($urandom), $urandom_range(1, IO_TIMEOUT + 3),
           8'($urandom), ($urandom_range(0, 9) == 0) ? -1 : 0);
    end
    settle();
    chk("queue_drained", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
